despachante_aprovados: RTL and testbench
========================================

# despachante_aprovados

Consumer of the active-node evaluator's outputs in the path-search engine: it selects one approved active node, commits that node's predecessor address to the predecessor memory, and deactivates the node in the evaluator. It then hands the node's address and distance to the neighbour-expansion stage over a valid/ready handshake. It drives the evaluator's deactivate port and the predecessor-memory write port, and consumes the evaluator's approved/address/distance/predecessor buses.

## Interface
Parameters:
- NUM_NA, 4, number of active-node slots in the evaluator
- ADDR_WIDTH, 5, node address width
- DISTANCIA_WIDTH, 5, accumulated distance width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- habilitar_in  in  1  allows new selections while high
- aa_aprovado_in  in  NUM_NA  per-slot approved flags
- aa_endereco_in  in  ADDR_WIDTH*NUM_NA  slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  slot distances, same packing
- aa_anterior_data_in  in  ADDR_WIDTH*NUM_NA  slot predecessor addresses, same packing
- aa_ocupado_in  in  1  evaluator busy
- aa_pronto_in  in  1  evaluator classification settled
- da_desativar_out  out  1  one-cycle deactivate pulse to the evaluator
- da_endereco_out  out  ADDR_WIDTH  address accompanying the deactivate pulse
- mem_anterior_we_out  out  1  predecessor-memory write enable
- mem_anterior_addr_out  out  ADDR_WIDTH  write address (the node)
- mem_anterior_data_out  out  ADDR_WIDTH  write data (the node's predecessor)
- da_valido_out  out  1  dispatched node valid
- da_no_endereco_out  out  ADDR_WIDTH  dispatched node address
- da_no_distancia_out  out  DISTANCIA_WIDTH  dispatched node distance
- expandir_pronto_in  in  1  expansion stage ready
- da_ocupado_out  out  1  high in every state except OCIOSO

## Operation
- FSM states: OCIOSO, SELECIONAR, GRAVAR, DESATIVAR, AGUARDAR, ENTREGAR.
- OCIOSO → SELECIONAR when habilitar_in & aa_pronto_in & |aa_aprovado_in & !aa_ocupado_in. Otherwise the FSM stays in OCIOSO.
- SELECIONAR: picks the first approved slot at or after the round-robin pointer, wrapping modulo NUM_NA. It latches the slot index, address, distance and predecessor into internal registers. If no slot is still approved, it returns to OCIOSO with no side effects.
- GRAVAR: mem_anterior_we_out=1 with the latched address and predecessor for exactly one cycle. → DESATIVAR.
- DESATIVAR: da_desativar_out=1 with da_endereco_out set to the latched address for exactly one cycle. → AGUARDAR.
- AGUARDAR: waits a minimum of 2 cycles (2-bit counter), then stays until aa_ocupado_in=0. → ENTREGAR.
- ENTREGAR: da_valido_out=1 with the latched address and distance, held stable until expandir_pronto_in=1 is seen on a rising edge. On that handshake:
  - the pointer becomes (latched index + 1) mod NUM_NA;
  - the FSM returns to OCIOSO.
- All outputs are decoded from registered state and latched data. No combinational path runs from an input to an output.
- Changes on the aa_* inputs after SELECIONAR do not affect the in-flight node.
- habilitar_in falling mid-operation: the current node completes through ENTREGAR, and no new selection is made.
- One node is in flight at a time.

## Timing
- Reset values:
  - state OCIOSO, pointer 0, latches 0;
  - every output 0, including da_ocupado_out.
- Reset asserted mid-operation: returns to OCIOSO immediately. No pending write or deactivate pulse is emitted after reset releases.
- Let the qualifying OCIOSO cycle be N:
  - SELECIONAR at N+1;
  - mem_anterior_we_out at N+2;
  - da_desativar_out at N+3;
  - AGUARDAR at N+4 and N+5;
  - da_valido_out earliest at N+6.
- If aa_ocupado_in stays high, each extra busy cycle delays da_valido_out by one cycle.
- A handshake completing at cycle M gives OCIOSO at M+1. The earliest next qualifying cycle is therefore M+1.
- A single node costs at least 7 cycles from qualification back to OCIOSO.

## Configuration
- DESPACHANTE_PRIORIDADE_DISTANCIA_EN defined: SELECIONAR picks the approved slot with the smallest distance. Ties go to the lowest index. The pointer is not used or updated.
- Not defined: round-robin selection as described above.
- The FSM, timing and all other behaviour are identical in both builds.

## Test plan
- Reset mid-flight: assert rst during GRAVAR → all outputs 0 in the same cycle. After release, no we/desativar pulse appears and the FSM is in OCIOSO.
- Single node: aprovado=4'b0100, slot2 endereco=9, distancia=12, anterior=3, ocupado=0, ready=1 → we at N+2 with addr 9, data 3. Desativar pulse at N+3 with endereco 9. valido at N+6 with 9/12. OCIOSO at N+7.
- Round-robin: aprovado=4'b1001 held, one node per pass → dispatch order slot0, slot3, slot0. The pointer wraps from 3 back to 0 and no slot is skipped.
- Backpressure and busy:
  - ocupado high for 4 cycles after the desativar pulse → valido delayed accordingly;
  - ready low for 3 cycles in ENTREGAR → valido and data held stable, no second we or desativar.
- Vanishing approval: aprovado=4'b0010 in OCIOSO, 4'b0000 in SELECIONAR → return to OCIOSO; we, desativar and valido all stay 0.
- With DESPACHANTE_PRIORIDADE_DISTANCIA_EN: aprovado=4'b1111, distances 7,3,3,9 → slot1 dispatched, distancia 3.

Source files
------------

// File: rtl/despachante_aprovados.sv
// despachante_aprovados
//
// Takes the evaluator's approved active nodes one at a time. For each node it:
//   1. picks one approved slot and latches its index, address, distance and predecessor;
//   2. writes the predecessor to the predecessor memory (one-cycle write);
//   3. sends a one-cycle deactivate pulse to the evaluator;
//   4. waits at least two cycles, then until the evaluator is no longer busy;
//   5. offers the node to the expansion stage over valid/ready.
// Only one node is in flight at a time.
//
// Slot selection is chosen at build time:
//   DESPACHANTE_PRIORIDADE_DISTANCIA_EN defined   : smallest distance wins, ties go to the
//                                                   lowest index; no pointer is kept.
//   DESPACHANTE_PRIORIDADE_DISTANCIA_EN undefined : round-robin from a pointer that moves
//                                                   past the last dispatched slot.
//
// Ports
//   clk, rst                        clock; asynchronous active-high reset
//   habilitar_in                    allows new selections while high
//   aa_aprovado_in                  per-slot approved flags
//   aa_endereco_in                  slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//   aa_distancia_in                 slot distances, same packing
//   aa_anterior_data_in             slot predecessor addresses, same packing
//   aa_ocupado_in, aa_pronto_in     evaluator busy / classification settled
//   da_desativar_out, da_endereco_out           deactivate pulse and its address
//   mem_anterior_we/addr/data_out               predecessor-memory write port
//   da_valido_out, da_no_endereco/distancia_out dispatched node (valid side)
//   expandir_pronto_in                          expansion stage ready
//   da_ocupado_out                              high whenever not idle
//
// Every output is decoded from registered state and latched data only.

module despachante_aprovados #(
  parameter int unsigned NUM_NA          = 4,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                habilitar_in,
  input  logic [NUM_NA-1:0]                   aa_aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]        aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0]   aa_distancia_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]        aa_anterior_data_in,
  input  logic                                aa_ocupado_in,
  input  logic                                aa_pronto_in,
  output logic                                da_desativar_out,
  output logic [ADDR_WIDTH-1:0]               da_endereco_out,
  output logic                                mem_anterior_we_out,
  output logic [ADDR_WIDTH-1:0]               mem_anterior_addr_out,
  output logic [ADDR_WIDTH-1:0]               mem_anterior_data_out,
  output logic                                da_valido_out,
  output logic [ADDR_WIDTH-1:0]               da_no_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]          da_no_distancia_out,
  input  logic                                expandir_pronto_in,
  output logic                                da_ocupado_out
);

  localparam int unsigned IdxW = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  typedef enum logic [2:0] {
    StOcioso,
    StSelecionar,
    StGravar,
    StDesativar,
    StAguardar,
    StEntregar
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      end_q, end_d;
  logic [DISTANCIA_WIDTH-1:0] dist_q, dist_d;
  logic [ADDR_WIDTH-1:0]      ant_q, ant_d;
  logic [1:0]                 cnt_q, cnt_d;
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;
`endif

  // Selection result for the current aa_* inputs.
  logic                       sel_found;
  int unsigned                sel_pos;
  logic [ADDR_WIDTH-1:0]      sel_end;
  logic [DISTANCIA_WIDTH-1:0] sel_dist;
  logic [ADDR_WIDTH-1:0]      sel_ant;

  always_comb begin : p_select
`ifdef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
    logic [DISTANCIA_WIDTH-1:0] best_dist;
    best_dist = '0;
`endif
    sel_found = 1'b0;
    sel_pos   = 0;
`ifdef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
    // Strict '<' keeps the lowest index on ties.
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (aa_aprovado_in[i] &&
          (!sel_found || aa_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH] < best_dist)) begin
        sel_found = 1'b1;
        sel_pos   = i;
        best_dist = aa_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH];
      end
    end
`else
    // First pass: slots at or after the pointer. Second pass: wrap to the low slots.
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (!sel_found && aa_aprovado_in[i] && (i >= 32'(ptr_q))) begin
        sel_found = 1'b1;
        sel_pos   = i;
      end
    end
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (!sel_found && aa_aprovado_in[i]) begin
        sel_found = 1'b1;
        sel_pos   = i;
      end
    end
`endif
    sel_end  = '0;
    sel_dist = '0;
    sel_ant  = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (sel_pos == i) begin
        sel_end  = aa_endereco_in[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_dist = aa_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH];
        sel_ant  = aa_anterior_data_in[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    end_d   = end_q;
    dist_d  = dist_q;
    ant_d   = ant_q;
    cnt_d   = cnt_q;
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`endif
    case (state_q)
      StOcioso: begin
        if (habilitar_in && aa_pronto_in && (|aa_aprovado_in) && !aa_ocupado_in) begin
          state_d = StSelecionar;
        end
      end
      StSelecionar: begin
        // Approval may have vanished since qualification; then leave without side effects.
        if (sel_found) begin
          end_d   = sel_end;
          dist_d  = sel_dist;
          ant_d   = sel_ant;
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
          idx_d   = IdxW'(sel_pos);
`endif
          state_d = StGravar;
        end else begin
          state_d = StOcioso;
        end
      end
      StGravar: begin
        state_d = StDesativar;
      end
      StDesativar: begin
        cnt_d   = 2'd0;
        state_d = StAguardar;
      end
      StAguardar: begin
        // cnt_q != 0 means the two-cycle minimum has elapsed.
        if ((cnt_q != 2'd0) && !aa_ocupado_in) begin
          state_d = StEntregar;
        end else if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StEntregar: begin
        if (expandir_pronto_in) begin
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
          ptr_d = (idx_q == IdxW'(NUM_NA - 1)) ? '0 : idx_q + 1'b1;
`endif
          state_d = StOcioso;
        end
      end
      default: begin
        state_d = StOcioso;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOcioso;
      end_q   <= '0;
      dist_q  <= '0;
      ant_q   <= '0;
      cnt_q   <= '0;
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
      idx_q   <= '0;
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      dist_q  <= dist_d;
      ant_q   <= ant_d;
      cnt_q   <= cnt_d;
`ifndef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Data buses are gated by their strobes so they read zero outside their cycles.
  always_comb begin : p_outputs
    mem_anterior_we_out   = (state_q == StGravar);
    da_desativar_out      = (state_q == StDesativar);
    da_valido_out         = (state_q == StEntregar);
    da_ocupado_out        = (state_q != StOcioso);
    mem_anterior_addr_out = mem_anterior_we_out ? end_q : '0;
    mem_anterior_data_out = mem_anterior_we_out ? ant_q : '0;
    da_endereco_out       = da_desativar_out ? end_q : '0;
    da_no_endereco_out    = da_valido_out ? end_q : '0;
    da_no_distancia_out   = da_valido_out ? dist_q : '0;
  end

endmodule

// File: tb/tb_despachante_aprovados.sv
// Randomized scoreboard bench for despachante_aprovados. The driver issues one node at a
// time, predicts the selected slot from the selection rule and queues the expected memory
// write, deactivate pulse and dispatch (with their cycle numbers). A separate monitor pops
// and compares whenever the DUT presents one of those outputs.

module tb_despachante_aprovados;

  localparam int NUM_NA = 4;
  localparam int AW     = 5;
  localparam int DW     = 5;
  localparam int EW     = AW * NUM_NA;
  localparam int DWW    = DW * NUM_NA;

  logic              clk = 1'b0;
  logic              rst;
  logic              habilitar_in;
  logic [NUM_NA-1:0] aa_aprovado_in;
  logic [EW-1:0]     aa_endereco_in;
  logic [DWW-1:0]    aa_distancia_in;
  logic [EW-1:0]     aa_anterior_data_in;
  logic              aa_ocupado_in;
  logic              aa_pronto_in;
  logic              da_desativar_out;
  logic [AW-1:0]     da_endereco_out;
  logic              mem_anterior_we_out;
  logic [AW-1:0]     mem_anterior_addr_out;
  logic [AW-1:0]     mem_anterior_data_out;
  logic              da_valido_out;
  logic [AW-1:0]     da_no_endereco_out;
  logic [DW-1:0]     da_no_distancia_out;
  logic              expandir_pronto_in;
  logic              da_ocupado_out;

  despachante_aprovados #(
    .NUM_NA          (NUM_NA),
    .ADDR_WIDTH      (AW),
    .DISTANCIA_WIDTH (DW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .habilitar_in          (habilitar_in),
    .aa_aprovado_in        (aa_aprovado_in),
    .aa_endereco_in        (aa_endereco_in),
    .aa_distancia_in       (aa_distancia_in),
    .aa_anterior_data_in   (aa_anterior_data_in),
    .aa_ocupado_in         (aa_ocupado_in),
    .aa_pronto_in          (aa_pronto_in),
    .da_desativar_out      (da_desativar_out),
    .da_endereco_out       (da_endereco_out),
    .mem_anterior_we_out   (mem_anterior_we_out),
    .mem_anterior_addr_out (mem_anterior_addr_out),
    .mem_anterior_data_out (mem_anterior_data_out),
    .da_valido_out         (da_valido_out),
    .da_no_endereco_out    (da_no_endereco_out),
    .da_no_distancia_out   (da_no_distancia_out),
    .expandir_pronto_in    (expandir_pronto_in),
    .da_ocupado_out        (da_ocupado_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int a;
    int d;
  } exp_t;

  exp_t q_we[$];
  exp_t q_des[$];
  exp_t q_val[$];
  int   ptr_m  = 0;
  int   hs_cnt = 0;

  // Reference selection: written straight from the selection rule.
  function automatic int model_sel(input logic [NUM_NA-1:0] apr, input logic [DWW-1:0] di,
                                   input int ptr);
    int best;
    best = -1;
`ifdef DESPACHANTE_PRIORIDADE_DISTANCIA_EN
    for (int i = 0; i < NUM_NA; i++) begin
      if (apr[i] && (best < 0 || di[DW*i +: DW] < di[DW*best +: DW])) best = i;
    end
    if (ptr < 0) best = -1;
`else
    for (int k = 0; k < NUM_NA; k++) begin
      if (best < 0 && apr[(ptr + k) % NUM_NA]) best = (ptr + k) % NUM_NA;
    end
`endif
    return best;
  endfunction

  // Monitor / scoreboard.
  initial begin : monitor
    bit   in_val;
    bit   chk_idle;
    exp_t e;
    in_val   = 1'b0;
    chk_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_val   = 1'b0;
        chk_idle = 1'b0;
      end else begin
        if (chk_idle) begin
          check("idle_after_handshake", da_ocupado_out, 0);
          chk_idle = 1'b0;
        end
        if (mem_anterior_we_out) begin
          check("we_expected", int'(q_we.size() > 0), 1);
          if (q_we.size() > 0) begin
            e = q_we.pop_front();
            check("we_cycle", cyc, e.cyc);
            check("we_addr", mem_anterior_addr_out, e.a);
            check("we_data", mem_anterior_data_out, e.d);
          end
        end
        if (da_desativar_out) begin
          check("desativar_expected", int'(q_des.size() > 0), 1);
          if (q_des.size() > 0) begin
            e = q_des.pop_front();
            check("desativar_cycle", cyc, e.cyc);
            check("desativar_addr", da_endereco_out, e.a);
          end
        end
        if (da_valido_out) begin
          check("valido_expected", int'(q_val.size() > 0), 1);
          if (q_val.size() > 0) begin
            e = q_val[0];
            if (!in_val) begin
              check("valido_first_cycle", cyc, e.cyc);
              in_val = 1'b1;
            end
            check("valido_addr", da_no_endereco_out, e.a);
            check("valido_dist", da_no_distancia_out, e.d);
            if (expandir_pronto_in) begin
              void'(q_val.pop_front());
              in_val   = 1'b0;
              chk_idle = 1'b1;
              hs_cnt++;
            end
          end
        end else if (in_val) begin
          check("valido_held", da_valido_out, 1);
          in_val = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    habilitar_in       = 1'b0;
    aa_pronto_in       = 1'b0;
    aa_ocupado_in      = 1'b0;
    aa_aprovado_in     = '0;
    expandir_pronto_in = 1'b0;
  endtask

  task automatic junk_aa();
    aa_aprovado_in      = NUM_NA'($urandom);
    aa_endereco_in      = EW'($urandom);
    aa_distancia_in     = DWW'($urandom);
    aa_anterior_data_in = EW'($urandom);
    habilitar_in        = 1'($urandom);
    aa_pronto_in        = 1'($urandom);
  endtask

  // One node: qualify in cycle n, hold aa_* through SELECIONAR, then scramble them.
  // Busy stays high through n+4+b; ready rises b+r cycles after the earliest dispatch.
  task automatic run_node(input logic [NUM_NA-1:0] apr, input logic [EW-1:0] en,
                          input logic [DWW-1:0] di, input logic [EW-1:0] an,
                          input int b, input int r);
    int   n, m, sel, hs0;
    exp_t e;
    habilitar_in        = 1'b1;
    aa_pronto_in        = 1'b1;
    aa_ocupado_in       = 1'b0;
    expandir_pronto_in  = 1'b0;
    aa_aprovado_in      = apr;
    aa_endereco_in      = en;
    aa_distancia_in     = di;
    aa_anterior_data_in = an;
    n   = cyc;
    hs0 = hs_cnt;
    sel = model_sel(apr, di, ptr_m);
    e.cyc = n + 2;
    e.a   = int'(en[AW*sel +: AW]);
    e.d   = int'(an[AW*sel +: AW]);
    q_we.push_back(e);
    e.cyc = n + 3;
    e.d   = 0;
    q_des.push_back(e);
    e.cyc = n + 6 + b;
    e.d   = int'(di[DW*sel +: DW]);
    q_val.push_back(e);
    m = n + 6 + b + r;
    step();
    for (int c = n + 2; c <= m; c++) begin
      step();
      junk_aa();
      if (c <= n + 4 + b)      aa_ocupado_in = 1'b1;
      else if (c == n + 5 + b) aa_ocupado_in = 1'b0;
      else                     aa_ocupado_in = 1'($urandom);
      if (c < n + 6 + b)       expandir_pronto_in = 1'($urandom);
      else                     expandir_pronto_in = (c >= m);
    end
    step();
    idle_inputs();
    ptr_m = (sel + 1) % NUM_NA;
    check("handshake_seen", hs_cnt, hs0 + 1);
  endtask

  initial begin : driver
    logic [EW-1:0]  en;
    logic [DWW-1:0] di;
    logic [EW-1:0]  an;
    rst = 1'b0;
    idle_inputs();
    aa_endereco_in      = '0;
    aa_distancia_in     = '0;
    aa_anterior_data_in = '0;
    #2 rst = 1'b1;
    step();
    step();
    check("rst_we", mem_anterior_we_out, 0);
    check("rst_desativar", da_desativar_out, 0);
    check("rst_valido", da_valido_out, 0);
    check("rst_ocupado", da_ocupado_out, 0);
    check("rst_mem_addr", mem_anterior_addr_out, 0);
    check("rst_mem_data", mem_anterior_data_out, 0);
    check("rst_des_addr", da_endereco_out, 0);
    check("rst_no_addr", da_no_endereco_out, 0);
    check("rst_no_dist", da_no_distancia_out, 0);
    rst = 1'b0;
    step();

    // Round-robin over slots 0 and 3: expect 0, 3, 0 in the default build.
    for (int p = 0; p < 3; p++) begin
      en = EW'($urandom); di = DWW'($urandom); an = EW'($urandom);
      run_node(4'b1001, en, di, an, 0, 0);
    end

    // Single node in slot 2: address 9, distance 12, predecessor 3.
    en = EW'($urandom); di = DWW'($urandom); an = EW'($urandom);
    en[AW*2 +: AW] = 5'd9;
    di[DW*2 +: DW] = 5'd12;
    an[AW*2 +: AW] = 5'd3;
    run_node(4'b0100, en, di, an, 0, 0);

    // Busy four cycles after the deactivate pulse, then ready held low three cycles.
    en = EW'($urandom); di = DWW'($urandom); an = EW'($urandom);
    run_node(4'b0110, en, di, an, 3, 3);

    // Distances 7,3,3,9 with all slots approved.
    en = EW'($urandom); an = EW'($urandom);
    di = {5'd9, 5'd3, 5'd3, 5'd7};
    run_node(4'b1111, en, di, an, 0, 1);

    // Conditions that must not start a selection.
    for (int k = 0; k < 9; k++) begin
      aa_aprovado_in = 4'b1111;
      habilitar_in   = (k >= 3 && k < 6) ? 1'b1 : (k < 3);
      aa_ocupado_in  = (k < 3);
      aa_pronto_in   = (k >= 6);
      if (k >= 6) habilitar_in = 1'b0;
      if (k < 3)  habilitar_in = 1'b1;
      if (k >= 3 && k < 6) aa_pronto_in = 1'b0;
      step();
      check("no_qualify_idle", da_ocupado_out, 0);
    end
    idle_inputs();
    step();

    // Approval vanishes during SELECIONAR.
    habilitar_in   = 1'b1;
    aa_pronto_in   = 1'b1;
    aa_aprovado_in = 4'b0010;
    step();
    check("vanish_selecting", da_ocupado_out, 1);
    idle_inputs();
    step();
    check("vanish_back_idle", da_ocupado_out, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("vanish_stays_idle", da_ocupado_out, 0);
    end

    // Reset while in GRAVAR.
    en = EW'($urandom); di = DWW'($urandom); an = EW'($urandom);
    habilitar_in        = 1'b1;
    aa_pronto_in        = 1'b1;
    aa_aprovado_in      = 4'b1000;
    aa_endereco_in      = en;
    aa_distancia_in     = di;
    aa_anterior_data_in = an;
    step();
    step();
    check("gravar_reached", mem_anterior_we_out, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", mem_anterior_we_out, 0);
    check("rst_mid_desativar", da_desativar_out, 0);
    check("rst_mid_valido", da_valido_out, 0);
    check("rst_mid_ocupado", da_ocupado_out, 0);
    check("rst_mid_mem_addr", mem_anterior_addr_out, 0);
    q_we.delete();
    q_des.delete();
    q_val.delete();
    ptr_m = 0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rst_mid_stays_idle", da_ocupado_out, 0);
    end

    // Randomized nodes, back to back.
    for (int p = 0; p < 40; p++) begin
      logic [NUM_NA-1:0] apr;
      apr = NUM_NA'($urandom_range(1, 15));
      en  = EW'($urandom); di = DWW'($urandom); an = EW'($urandom);
      run_node(apr, en, di, an, $urandom_range(0, 4), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 3; k++) step();
      end
    end

    for (int k = 0; k < 10; k++) step();
    check("leftover_we", q_we.size(), 0);
    check("leftover_desativar", q_des.size(), 0);
    check("leftover_valido", q_val.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
